// File: rtl/syncfifo.sv
// Single-clock FIFO with binary wrap-bit pointers, programmable almost flags,
// sticky overflow/underflow, synchronous flush and selectable FWFT or registered read.
module syncfifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter bit FWFT       = 1'b1,
  parameter int AFULL_TH   = 12,
  parameter int AEMPTY_TH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wpush,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic                  overflow,
  input  logic                  rpull,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  rempty,
  output logic                  ralmost_empty,
  output logic                  underflow,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] AFULL_C  = AFULL_TH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = AEMPTY_TH[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wptr;
  logic [ADDR_WIDTH:0]   rptr;
  logic [ADDR_WIDTH-1:0] widx;
  logic [ADDR_WIDTH-1:0] ridx;
  logic                  push_ok;
  logic                  pull_ok;

  assign widx  = wptr[ADDR_WIDTH-1:0];
  assign ridx  = rptr[ADDR_WIDTH-1:0];
  assign count = wptr - rptr;

  // Full when indices match but the wrap bits differ; empty when pointers are equal.
  assign wfull         = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) && (widx == ridx);
  assign rempty        = (wptr == rptr);
  assign walmost_full  = (count >= AFULL_C);
  assign ralmost_empty = (count <= AEMPTY_C);

  assign push_ok = wpush && !wfull && !flush;
  assign pull_ok = rpull && !rempty && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pull_ok) rptr <= rptr + 1'b1;
      if (wpush && wfull) overflow <= 1'b1;
      if (rpull && rempty) underflow <= 1'b1;
    end
  end

  // Storage is deliberately left out of reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[widx] <= wdata;
  end

  generate
    if (FWFT) begin : g_fwft
      assign rdata  = mem[ridx];
      assign rvalid = !rempty;
    end else begin : g_registered
      logic [DATA_WIDTH-1:0] rdata_q;
      logic                  rvalid_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else if (flush) begin
          rvalid_q <= 1'b0;
        end else begin
          rvalid_q <= pull_ok;
          if (pull_ok) rdata_q <= mem[ridx];
        end
      end

      assign rdata  = rdata_q;
      assign rvalid = rvalid_q;
    end
  endgenerate

endmodule

// File: tb/tb_syncfifo.sv
// Drives an FWFT and a registered-read syncfifo with identical stimulus and
// compares both against a queue-based reference model every cycle.
module tb_syncfifo;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          wpush = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          rpull = 1'b0;

  logic          wfull, walmost_full, overflow, rvalid, rempty, ralmost_empty, underflow;
  logic [DW-1:0] rdata;
  logic [AW:0]   count;

  logic          reg_wfull, reg_walmost_full, reg_overflow, reg_rvalid;
  logic          reg_rempty, reg_ralmost_empty, reg_underflow;
  logic [DW-1:0] reg_rdata;
  logic [AW:0]   reg_count;

  // Reference model state
  logic [DW-1:0] q[$];
  bit            m_overflow;
  bit            m_underflow;
  bit            m_rvalid_reg;
  logic [DW-1:0] m_rdata_reg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  syncfifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1'b1), .AFULL_TH(12), .AEMPTY_TH(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wpush(wpush), .wdata(wdata),
    .wfull(wfull), .walmost_full(walmost_full), .overflow(overflow),
    .rpull(rpull), .rdata(rdata), .rvalid(rvalid), .rempty(rempty),
    .ralmost_empty(ralmost_empty), .underflow(underflow), .count(count)
  );

  syncfifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1'b0), .AFULL_TH(12), .AEMPTY_TH(2)) dut_reg (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wpush(wpush), .wdata(wdata),
    .wfull(reg_wfull), .walmost_full(reg_walmost_full), .overflow(reg_overflow),
    .rpull(rpull), .rdata(reg_rdata), .rvalid(reg_rvalid), .rempty(reg_rempty),
    .ralmost_empty(reg_ralmost_empty), .underflow(reg_underflow), .count(reg_count)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Model works from the FIFO's rules: occupancy is the queue size.
  task automatic modelStep(input bit push, input logic [DW-1:0] data, input bit pull, input bit fl);
    bit full;
    bit empty;
    full  = (q.size() == DEPTH);
    empty = (q.size() == 0);
    if (fl) begin
      q.delete();
      m_overflow   = 1'b0;
      m_underflow  = 1'b0;
      m_rvalid_reg = 1'b0;
    end else begin
      m_rvalid_reg = pull && !empty;
      if (pull && !empty) m_rdata_reg = q.pop_front();
      if (push && !full) q.push_back(data);
      if (push && full) m_overflow = 1'b1;
      if (pull && empty) m_underflow = 1'b1;
    end
  endtask

  task automatic checkState();
    int n;
    n = q.size();
    checkOutput("count",         64'(count),         64'(n));
    checkOutput("rempty",        64'(rempty),        64'(n == 0));
    checkOutput("wfull",         64'(wfull),         64'(n == DEPTH));
    checkOutput("walmost_full",  64'(walmost_full),  64'(n >= 12));
    checkOutput("ralmost_empty", 64'(ralmost_empty), 64'(n <= 2));
    checkOutput("overflow",      64'(overflow),      64'(m_overflow));
    checkOutput("underflow",     64'(underflow),     64'(m_underflow));
    checkOutput("rvalid",        64'(rvalid),        64'(n != 0));
    if (n != 0) checkOutput("rdata_fwft", 64'(rdata), 64'(q[0]));
    checkOutput("reg_count",     64'(reg_count),     64'(n));
    checkOutput("reg_overflow",  64'(reg_overflow),  64'(m_overflow));
    checkOutput("reg_underflow", 64'(reg_underflow), 64'(m_underflow));
    checkOutput("reg_rvalid",    64'(reg_rvalid),    64'(m_rvalid_reg));
    checkOutput("reg_rdata",     64'(reg_rdata),     64'(m_rdata_reg));
  endtask

  task automatic applyStimulus(input bit push, input logic [DW-1:0] data, input bit pull, input bit fl);
    wpush = push;
    wdata = data;
    rpull = pull;
    flush = fl;
    @(posedge clk);
    modelStep(push, data, pull, fl);
    #1;
    checkState();
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    wpush = 1'b0;
    rpull = 1'b0;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    m_overflow   = 1'b0;
    m_underflow  = 1'b0;
    m_rvalid_reg = 1'b0;
    m_rdata_reg  = '0;
    rst_n = 1'b1;
    checkState();
  endtask

  initial begin
    logic [DW-1:0] val;

    applyReset();

    // Fill with 0x2..0x11, overfill once, then drain in order
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, DW'(i + 2), 1'b0, 1'b0);
    checkOutput("fill_wfull", 64'(wfull), 64'd1);
    applyStimulus(1'b1, 32'hDEAD, 1'b0, 1'b0);
    checkOutput("fill_overflow", 64'(overflow), 64'd1);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("drain_rempty", 64'(rempty), 64'd1);
    checkOutput("drain_last_reg", 64'(reg_rdata), 64'h11);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    // Simultaneous push+pull at count 5, when full, and when empty
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, DW'(32'h100 + i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, DW'(32'h200 + i), 1'b1, 1'b0);
    checkOutput("simul_count5", 64'(count), 64'd5);
    while (q.size() < DEPTH) applyStimulus(1'b1, $urandom, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hBAD0, 1'b1, 1'b0);
    checkOutput("simul_full_count", 64'(count), 64'd15);
    checkOutput("simul_full_ovf", 64'(overflow), 64'd1);
    while (q.size() > 0) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'hC0DE, 1'b1, 1'b0);
    checkOutput("simul_empty_count", 64'(count), 64'd1);
    checkOutput("simul_empty_udf", 64'(underflow), 64'd1);
    checkOutput("simul_empty_head", 64'(rdata), 64'hC0DE);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    // Wrap: 20 pushes interleaved with 20 pulls
    for (int i = 0; i < 40; i++) applyStimulus(i % 2 == 0, DW'(32'h300 + i / 2), i % 2 == 1, 1'b0);
    checkOutput("wrap_overflow", 64'(overflow), 64'd0);
    checkOutput("wrap_underflow", 64'(underflow), 64'd0);
    checkOutput("wrap_last_reg", 64'(reg_rdata), 64'h313);

    // Flush at count 7 with overflow set and wpush asserted
    while (q.size() < DEPTH) applyStimulus(1'b1, $urandom, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h1, 1'b0, 1'b0);
    while (q.size() > 7) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("preflush_ovf", 64'(overflow), 64'd1);
    applyStimulus(1'b1, 32'hF00D, 1'b0, 1'b1);
    checkOutput("flush_count", 64'(count), 64'd0);
    checkOutput("flush_rempty", 64'(rempty), 64'd1);
    checkOutput("flush_ovf", 64'(overflow), 64'd0);

    // Registered read: push 0xA5, pull, then idle
    applyStimulus(1'b1, 32'hA5, 1'b0, 1'b0);
    checkOutput("a5_fwft_head", 64'(rdata), 64'hA5);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("a5_rvalid", 64'(reg_rvalid), 64'd1);
    checkOutput("a5_rdata", 64'(reg_rdata), 64'hA5);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("a5_rvalid_drop", 64'(reg_rvalid), 64'd0);
    checkOutput("a5_rdata_hold", 64'(reg_rdata), 64'hA5);

    // Random traffic in phases biased toward filling, draining and balance
    for (int phase = 0; phase < 6; phase++) begin
      int push_pct;
      int pull_pct;
      push_pct = (phase % 3 == 0) ? 80 : (phase % 3 == 1) ? 20 : 50;
      pull_pct = 100 - push_pct;
      for (int i = 0; i < 80; i++) begin
        val = $urandom;
        applyStimulus($urandom_range(0, 99) < push_pct, val,
                      $urandom_range(0, 99) < pull_pct, $urandom_range(0, 99) < 2);
      end
    end

    applyReset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
